// File: rtl/alu_pkg.sv
// Shared constants, opcodes, FSM state and operand payload for the serial 32-bit ALU.
package alu_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned SEL_W = 4;

  // Arithmetic group (00xx): a + {0 | b | ~b | all-ones} + cin
  localparam logic [SEL_W-1:0] ADD_A   = 4'b0000;
  localparam logic [SEL_W-1:0] ADD_AB  = 4'b0001;
  localparam logic [SEL_W-1:0] ADD_ANB = 4'b0010;
  localparam logic [SEL_W-1:0] DEC_A   = 4'b0011;
  // Logic group (01xx)
  localparam logic [SEL_W-1:0] AND     = 4'b0100;
  localparam logic [SEL_W-1:0] OR      = 4'b0101;
  localparam logic [SEL_W-1:0] XOR     = 4'b0110;
  localparam logic [SEL_W-1:0] NOT     = 4'b0111;
  // Shift group (1xxx), realised by passing a neighbour bit through the slice
  localparam logic [SEL_W-1:0] SHR     = 4'b1000;
  localparam logic [SEL_W-1:0] SHL     = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Operands captured on accept
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [SEL_W-1:0] sel;
  } op_t;

endpackage

// File: rtl/alu_1bit.sv
// Combinational 1-bit ALU slice; sel[3]=1 simply passes a through.
module alu_1bit
  import alu_pkg::*;
(
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic [SEL_W-1:0] sel,
  output logic             f_c,
  output logic             cout_c
);

  logic bb;

  // Second adder operand chosen by the low opcode bits
  always_comb begin
    bb = 1'b0;
    unique case (sel[1:0])
      2'b00: bb = 1'b0;
      2'b01: bb = b;
      2'b10: bb = ~b;
      2'b11: bb = 1'b1;
      default: bb = 1'b0;
    endcase
  end

  // Full-add for the arithmetic group, bitwise ops for the logic group
  always_comb begin
    f_c    = a;
    cout_c = 1'b0;
    if (sel[3:2] == 2'b00) begin
      f_c    = a ^ bb ^ cin;
      cout_c = (a & bb) | (a & cin) | (bb & cin);
    end else if (sel[3:2] == 2'b01) begin
      unique case (sel[1:0])
        2'b00: f_c = a & b;
        2'b01: f_c = a | b;
        2'b10: f_c = a ^ b;
        2'b11: f_c = ~a;
        default: f_c = a;
      endcase
    end
  end

endmodule

// File: rtl/alu_serial32.sv
// Bit-serial 32-bit ALU: one slice, LSB first, valid/ready request and response.
module alu_serial32
  import alu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             zero_o
);

  state_e           state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  op_t              op_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             zero_q;

  logic             accept;
  logic             last;
  logic             s_a, s_b, s_cin, s_f, s_cout;
  logic [SEL_W-1:0] s_sel;
  logic             final_cout;
  logic [WIDTH-1:0] result_next;

  assign accept      = req_valid_i && req_ready_q;
  assign last        = (idx_q == IDX_W'(WIDTH - 1));
  assign result_next = {s_f, result_q[WIDTH-1:1]};

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign result_o    = result_q;
  assign cout_o      = cout_q;
  assign zero_o      = zero_q;

  // State and handshake-flag registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)      state_d = RUN;
      RUN:     if (last)        state_d = DONE;
      DONE:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags follow the upcoming state so they are registered
  always_comb begin
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    unique case (state_d)
      IDLE:    req_ready_d = 1'b1;
      DONE:    rsp_valid_d = 1'b1;
      default: ;
    endcase
  end

  // Slice input steering per opcode group; shifts route the neighbour bit as a pass-through
  always_comb begin
    s_a        = op_q.a[idx_q];
    s_b        = op_q.b[idx_q];
    s_sel      = op_q.sel;
    s_cin      = 1'b0;
    final_cout = 1'b0;
    unique case (op_q.sel[3:2])
      2'b00: begin
        s_cin      = (idx_q == '0) ? op_q.cin : carry_q;
        final_cout = s_cout;
      end
      2'b01: begin
        s_cin      = 1'b0;
        final_cout = 1'b0;
      end
      2'b10: begin
        s_sel      = ADD_A;
        s_a        = last ? 1'b0 : op_q.a[idx_q + IDX_W'(1)];
        final_cout = op_q.a[0];
      end
      2'b11: begin
        s_sel      = ADD_A;
        s_a        = (idx_q == '0) ? 1'b0 : op_q.a[idx_q - IDX_W'(1)];
        final_cout = op_q.a[WIDTH-1];
      end
      default: ;
    endcase
  end

  alu_1bit u_slice (
    .a      (s_a),
    .b      (s_b),
    .cin    (s_cin),
    .sel    (s_sel),
    .f_c    (s_f),
    .cout_c (s_cout)
  );

  // Operand capture, bit index, carry and result shift register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q     <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= '{a: a_i, b: b_i, cin: cin_i, sel: sel_i};
            idx_q   <= '0;
            carry_q <= 1'b0;
          end
        end
        RUN: begin
          result_q <= result_next;
          carry_q  <= s_cout;
          idx_q    <= idx_q + IDX_W'(1);
          if (last) begin
            cout_q <= final_cout;
            zero_q <= (result_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial32.sv
// Directed bench for alu_serial32 with an expected-result scoreboard.
module tb_alu_serial32;
  import alu_pkg::*;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;
  } exp_t;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic [SEL_W-1:0] sel_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [WIDTH-1:0] result_o;
  logic             cout_o;
  logic             zero_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  int   lat;

  alu_serial32 dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .cin_i       (cin_i),
    .sel_i       (sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .result_o    (result_o),
    .cout_o      (cout_o),
    .zero_o      (zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written directly from the opcode definitions
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic [3:0] sel);
    logic [32:0] s;
    exp_t e;
    e = '0;
    s = '0;
    case (sel)
      ADD_A:   s = {1'b0, a} + 33'(cin);
      ADD_AB:  s = {1'b0, a} + {1'b0, b} + 33'(cin);
      ADD_ANB: s = {1'b0, a} + {1'b0, ~b} + 33'(cin);
      DEC_A:   s = {1'b0, a} + 33'h0FFFFFFFF + 33'(cin);
      AND:     s = {1'b0, a & b};
      OR:      s = {1'b0, a | b};
      XOR:     s = {1'b0, a ^ b};
      NOT:     s = {1'b0, ~a};
      SHR:     s = {a[0], 1'b0, a[31:1]};
      SHL:     s = {a[31], a[30:0], 1'b0};
      default: s = '0;
    endcase
    e.result = s[31:0];
    e.cout   = s[32];
    e.zero   = (s[31:0] == 32'd0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one request for one cycle; garbage on the operands afterwards
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic [3:0] sel);
    chk("ready_before_req", 32'(req_ready_o), 32'd1);
    a_i = a; b_i = b; cin_i = cin; sel_i = sel;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    a_i = $urandom; b_i = $urandom; cin_i = 1'b1; sel_i = 4'b0110;
    lat = 1;
  endtask

  // Wait (bounded) for rsp_valid_o, check latency and the scoreboard head
  task automatic wait_rsp(input string tag);
    exp_t e;
    while (!rsp_valid_o && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd33);
    chk({tag, "_ready_low"}, 32'(req_ready_o), 32'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_result"}, result_o, e.result);
      chk({tag, "_cout"}, 32'(cout_o), 32'(e.cout));
      chk({tag, "_zero"}, 32'(zero_o), 32'(e.zero));
    end
  endtask

  task automatic release_rsp(input string tag);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    chk({tag, "_idle_ready"}, 32'(req_ready_o), 32'd1);
    chk({tag, "_idle_valid"}, 32'(rsp_valid_o), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [3:0] sel,
                        input logic [31:0] er, input logic ec);
    exp_t e;
    e.result = er;
    e.cout   = ec;
    e.zero   = (er == 32'd0);
    sb.push_back(e);
    issue(a, b, cin, sel);
    wait_rsp(tag);
    release_rsp(tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    chk({tag, "_valid"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, "_result"}, result_o, 32'd0);
    chk({tag, "_cout"}, 32'(cout_o), 32'd0);
    chk({tag, "_zero"}, 32'(zero_o), 32'd1);
  endtask

  initial begin
    logic [3:0]  ops [10];
    logic [31:0] ra, rb, hold_r;
    logic        rc, hold_c, hold_z;
    logic [3:0]  rs;
    exp_t        e;

    ops = '{ADD_A, ADD_AB, ADD_ANB, DEC_A, AND, OR, XOR, NOT, SHR, SHL};
    rst_i = 1'b1; req_valid_i = 1'b0; rsp_ready_i = 1'b0;
    a_i = '0; b_i = '0; cin_i = 1'b0; sel_i = '0;
    tick();
    tick();
    check_reset_values("reset");
    rst_i = 1'b0;
    tick();

    // Arithmetic
    run_op("add_ab_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, ADD_AB, 32'h0000_0000, 1'b1);
    run_op("sub_5_3",     32'd5, 32'd3, 1'b1, ADD_ANB, 32'h0000_0002, 1'b1);
    run_op("dec_0",       32'd0, 32'hDEAD_BEEF, 1'b0, DEC_A, 32'hFFFF_FFFF, 1'b0);
    run_op("add_a_cin",   32'd7, 32'hFFFF_FFFF, 1'b1, ADD_A, 32'd8, 1'b0);

    // Logic
    run_op("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, AND, 32'hF000_F000, 1'b0);
    run_op("or",  32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, OR,  32'hFFF0_FFF0, 1'b0);
    run_op("xor", 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, XOR, 32'h0FF0_0FF0, 1'b0);
    run_op("not", 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, NOT, 32'h0F0F_0F0F, 1'b0);

    // Shifts
    run_op("shl", 32'h8000_0001, 32'h0, 1'b1, SHL, 32'h0000_0002, 1'b1);
    run_op("shr", 32'h8000_0001, 32'h0, 1'b1, SHR, 32'h4000_0000, 1'b1);

    // A few random operations against the model
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      rs = ops[$urandom_range(0, 9)];
      e  = model(ra, rb, rc, rs);
      run_op("random", ra, rb, rc, rs, e.result, e.cout);
    end

    // Backpressure: response held for 10 cycles, a stray request is ignored
    e = model(32'h1234_5678, 32'h1111_1111, 1'b0, ADD_AB);
    sb.push_back(e);
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, ADD_AB);
    wait_rsp("bp");
    hold_r = result_o; hold_c = cout_o; hold_z = zero_o;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        a_i = 32'h5; b_i = 32'h5; sel_i = ADD_AB; req_valid_i = 1'b1;
      end
      tick();
      req_valid_i = 1'b0;
      chk("bp_valid_held", 32'(rsp_valid_o), 32'd1);
      chk("bp_ready_low", 32'(req_ready_o), 32'd0);
      chk("bp_result_held", result_o, hold_r);
      chk("bp_cout_held", 32'(cout_o), 32'(hold_c));
      chk("bp_zero_held", 32'(zero_o), 32'(hold_z));
    end
    release_rsp("bp");
    run_op("after_bp", 32'h1, 32'h2, 1'b0, OR, 32'h3, 1'b0);

    // Reset while bit 12 is being processed, then a fresh add
    issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, ADD_AB);
    repeat (12) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_reset_values("midrun_reset");
    tick();
    chk("midrun_still_idle", 32'(rsp_valid_o), 32'd0);
    run_op("add_1_1", 32'd1, 32'd1, 1'b0, ADD_AB, 32'd2, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_serial32.md
ALU_SERIAL32 -- requirements
Module: alu_serial32

Interface
REQ-001 SHALL have port clk_i, input, width 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, width 1: reset, synchronous and active-high.
REQ-003 SHALL have port req_valid_i, input, width 1: the request operands and opcode are valid.
REQ-004 SHALL have port req_ready_o, output, width 1: the block can accept a request; high only in IDLE.
REQ-005 SHALL have port a_i, input, width 32: operand A, sampled on accept.
REQ-006 SHALL have port b_i, input, width 32: operand B, sampled on accept.
REQ-007 SHALL have port cin_i, input, width 1: carry-in to bit 0, sampled on accept.
REQ-008 SHALL have port sel_i, input, width 4: opcode, encoded as in the 1-bit slice, sampled on accept.
REQ-009 SHALL have port rsp_valid_o, output, width 1: the result is valid; high only in DONE.
REQ-010 SHALL have port rsp_ready_i, input, width 1: the consumer accepts the result.
REQ-011 SHALL have port result_o, output, width 32: the operation result.
REQ-012 SHALL have port cout_o, output, width 1: final carry or shifted-out bit.
REQ-013 SHALL have port zero_o, output, width 1: set when result_o equals 0.

Function
REQ-014 SHALL use three states, IDLE, RUN and DONE, with these transitions:
- IDLE to RUN on req_valid_i&&req_ready_o.
- RUN to DONE when the bit index is 31.
- DONE to IDLE on rsp_ready_i.
REQ-015 SHALL, on accept, latch a_i, b_i, cin_i and sel_i, and clear the 5-bit bit index to 0.
REQ-016 SHALL process one bit per RUN cycle, LSB first, through a single 1-bit slice; latency from accept to rsp_valid_o is exactly 33 cycles.
REQ-017 SHALL, for sel[3]=0, drive slice a=A[i], b=B[i], sel=sel[3:0] and write slice f to result bit i.
REQ-018 SHALL, for arithmetic ops (sel 00xx), drive slice cin=cin_i at i=0 and cin=registered slice cout of bit i-1 at i>0; cout_o is the bit-31 slice cout.
REQ-019 SHALL, for logic ops (sel 01xx), drive slice cin=0; cout_o is 0.
REQ-020 SHALL implement shr (sel 10xx) by driving the slice with sel=0000, cin=0 and a=A[i+1]; a=0 at i=31; cout_o=A[0].
REQ-021 SHALL implement shl (sel 11xx) by driving the slice with sel=0000, cin=0 and a=A[i-1]; a=0 at i=0; cout_o=A[31].
REQ-022 SHALL hold result_o, cout_o and zero_o stable in DONE until the handshake completes; rsp_ready_i is ignored outside DONE.
REQ-023 SHALL ignore req_valid_i while in RUN or DONE; no request is queued.
REQ-024 SHALL hold result_o, cout_o and zero_o at their last values in IDLE; these outputs are undefined during RUN.

Reset
REQ-025 SHALL, on rst_i high at a clock edge, enter IDLE from any state, including mid-RUN, and abandon any in-flight operation.
REQ-026 SHALL reset outputs and internal state to: req_ready_o=1, rsp_valid_o=0, result_o=0, cout_o=0, zero_o=1, bit index=0, carry register=0.

Structure
REQ-027 SHALL place the opcode constants (ADD_A, ADD_AB, ADD_ANB, DEC_A, AND, OR, XOR, NOT, SHR, SHL), the state enum and the width constant 32 in a shared package, alu_pkg.
REQ-028 SHALL instantiate exactly one sub-module, alu_1bit, as the datapath slice; the surrounding logic is the controller and the shift register.

Verification
REQ-029 SHALL verify ADD_AB: A=0xFFFFFFFF, B=0x00000001, sel=0001, cin=0 -> result 0x00000000, cout 1, zero 1, rsp_valid_o exactly 33 cycles after accept.
REQ-030 SHALL verify subtract: A=5, B=3, sel=0010, cin=1 -> result 0x00000002, cout 1; then DEC_A with A=0, sel=0011, cin=0 -> result 0xFFFFFFFF, cout 0.
REQ-031 SHALL verify logic: A=0xF0F0F0F0, B=0xFF00FF00 -> AND 0xF000F000, OR 0xFFF0FFF0, XOR 0x0FF00FF0, NOT 0x0F0F0F0F, cout 0 for all.
REQ-032 SHALL verify shifts: A=0x80000001 -> shl result 0x00000002 with cout 1; shr result 0x40000000 with cout 1.
REQ-033 SHALL verify backpressure: hold rsp_ready_i=0 for 10 cycles in DONE -> outputs stable and a req_valid_i pulse is ignored; release -> IDLE next cycle, then a new request is accepted.
REQ-034 SHALL verify reset mid-operation: assert rst_i at bit index 12 -> IDLE with the reset values of REQ-026 next cycle, and a following ADD of 1+1 -> result 0x00000002.
